// File: rtl/lowx_arbiter_pkg.sv
// Shared types for the lowX memory-port arbiter: FSM states, owner tags,
// latched request and routed response records.
package lowx_arbiter_pkg;

  localparam int unsigned LOWX_XLEN     = 32;
  localparam int unsigned LOWX_BLK_SIZE = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } lowx_arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } lowx_owner_e;

  typedef struct packed {
    logic                     valid;
    logic [LOWX_XLEN-1:0]     addr;
    logic                     rw;
    logic [LOWX_BLK_SIZE-1:0] wdata;
    logic                     uncached;
  } lowx_req_t;

  typedef struct packed {
    logic                     valid;
    logic [LOWX_BLK_SIZE-1:0] blk;
  } lowx_res_t;

  // Response record whose block is forced to zero unless it is valid.
  function automatic lowx_res_t lowx_res_pass(input logic valid,
                                              input logic [LOWX_BLK_SIZE-1:0] blk);
    lowx_res_t r;
    r.valid = valid;
    r.blk   = valid ? blk : '0;
    return r;
  endfunction

endpackage

// File: rtl/lowx_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the side that did not win last time
// is granted. req[0]/gnt[0] is the I side, req[1]/gnt[1] the D side.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/lowx_arbiter.sv
// Shares the single lowX memory port between the fetch align buffer (I) and
// the dcache miss path (D); one transaction outstanding, responses routed back.
module lowx_arbiter
  import lowx_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = LOWX_XLEN,
  parameter int unsigned BLK_SIZE = LOWX_BLK_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                i_valid_i,
  input  logic [XLEN-1:0]     i_addr_i,
  input  logic                i_uncached_i,
  output logic                i_ready_o,
  output logic                i_res_valid_o,
  output logic [BLK_SIZE-1:0] i_res_blk_o,
  input  logic                d_valid_i,
  input  logic [XLEN-1:0]     d_addr_i,
  input  logic                d_rw_i,
  input  logic [BLK_SIZE-1:0] d_wdata_i,
  input  logic                d_uncached_i,
  output logic                d_ready_o,
  output logic                d_res_valid_o,
  output logic [BLK_SIZE-1:0] d_res_blk_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic                mem_rw_o,
  output logic [BLK_SIZE-1:0] mem_wdata_o,
  output logic                mem_uncached_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

  lowx_arb_state_e state_q;
  lowx_owner_e     owner_q;
  lowx_owner_e     last_q;
  logic            drop_q;
  lowx_req_t       req_q;

  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       in_idle;
  logic       res_hit;
  logic       i_flush_busy;
  lowx_res_t  i_res;
  lowx_res_t  d_res;

  assign req_vec = {d_valid_i, i_valid_i & ~flush_i};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_q == OWN_D),
    .gnt        (gnt)
  );

  // Outputs are gated by rst_i so the port is quiet for the whole reset cycle.
  assign in_idle      = (state_q == ARB_IDLE) & ~rst_i;
  assign res_hit      = (state_q == ARB_WAIT) & mem_res_valid_i & ~rst_i;
  assign i_flush_busy = flush_i & (owner_q == OWN_I) & (state_q != ARB_IDLE);

  assign i_ready_o = in_idle & gnt[0];
  assign d_ready_o = in_idle & gnt[1];

  // A flush arriving on the response cycle itself also swallows the I block.
  assign i_res = lowx_res_pass(res_hit & (owner_q == OWN_I) & ~drop_q & ~flush_i,
                               mem_res_blk_i);
  assign d_res = lowx_res_pass(res_hit & (owner_q == OWN_D), mem_res_blk_i);

  assign i_res_valid_o = i_res.valid;
  assign i_res_blk_o   = i_res.blk;
  assign d_res_valid_o = d_res.valid;
  assign d_res_blk_o   = d_res.blk;

  assign mem_valid_o    = req_q.valid & ~rst_i;
  assign mem_addr_o     = req_q.addr;
  assign mem_rw_o       = req_q.rw;
  assign mem_wdata_o    = req_q.wdata;
  assign mem_uncached_o = req_q.uncached;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      drop_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt[0]) begin
            req_q.valid    <= 1'b1;
            req_q.addr     <= i_addr_i;
            req_q.rw       <= 1'b0;
            req_q.wdata    <= '0;
            req_q.uncached <= i_uncached_i;
            owner_q        <= OWN_I;
            last_q         <= OWN_I;
            state_q        <= ARB_REQ;
          end else if (gnt[1]) begin
            req_q.valid    <= 1'b1;
            req_q.addr     <= d_addr_i;
            req_q.rw       <= d_rw_i;
            req_q.wdata    <= d_wdata_i;
            req_q.uncached <= d_uncached_i;
            owner_q        <= OWN_D;
            last_q         <= OWN_D;
            state_q        <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (i_flush_busy) drop_q <= 1'b1;
          if (mem_ready_i) begin
            req_q.valid <= 1'b0;
            state_q     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_res_valid_i) begin
            drop_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end else if (i_flush_busy) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  a_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    !(i_ready_o && d_ready_o));

  a_ready_idle : assert property (@(posedge clk_i) disable iff (rst_i)
    (i_ready_o || d_ready_o) |-> (state_q == ARB_IDLE));

  a_mem_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_valid_o && !mem_ready_i) |=>
      (mem_valid_o && $stable(mem_addr_o) && $stable(mem_rw_o) &&
       $stable(mem_wdata_o) && $stable(mem_uncached_o)));

endmodule

// File: tb/tb_lowx_arbiter.sv
// Directed bench for lowx_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, ahead of the next rising edge.
module tb_lowx_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         i_valid_i;
  logic [31:0]  i_addr_i;
  logic         i_uncached_i;
  logic         i_ready_o;
  logic         i_res_valid_o;
  logic [127:0] i_res_blk_o;
  logic         d_valid_i;
  logic [31:0]  d_addr_i;
  logic         d_rw_i;
  logic [127:0] d_wdata_i;
  logic         d_uncached_i;
  logic         d_ready_o;
  logic         d_res_valid_o;
  logic [127:0] d_res_blk_o;
  logic         mem_valid_o;
  logic         mem_ready_i;
  logic [31:0]  mem_addr_o;
  logic         mem_rw_o;
  logic [127:0] mem_wdata_o;
  logic         mem_uncached_o;
  logic         mem_res_valid_i;
  logic [127:0] mem_res_blk_i;

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [127:0] BLK1  = 128'hAAAAAAAA_BBBBBBBB_11111111_22222222;
  localparam logic [127:0] BLK2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK3  = 128'h33333333_44444444_55555555_66666666;
  localparam logic [127:0] BLK4  = 128'h77777777_88888888_99999999_00000000;
  localparam logic [127:0] BLK5  = 128'hCAFEF00D_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] WDATA = {4{32'hDEADBEEF}};

  always #5 clk_i = ~clk_i;

  lowx_arbiter #(.XLEN(32), .BLK_SIZE(128)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .i_valid_i       (i_valid_i),
    .i_addr_i        (i_addr_i),
    .i_uncached_i    (i_uncached_i),
    .i_ready_o       (i_ready_o),
    .i_res_valid_o   (i_res_valid_o),
    .i_res_blk_o     (i_res_blk_o),
    .d_valid_i       (d_valid_i),
    .d_addr_i        (d_addr_i),
    .d_rw_i          (d_rw_i),
    .d_wdata_i       (d_wdata_i),
    .d_uncached_i    (d_uncached_i),
    .d_ready_o       (d_ready_o),
    .d_res_valid_o   (d_res_valid_o),
    .d_res_blk_o     (d_res_blk_o),
    .mem_valid_o     (mem_valid_o),
    .mem_ready_i     (mem_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_rw_o        (mem_rw_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_uncached_o  (mem_uncached_o),
    .mem_res_valid_i (mem_res_valid_i),
    .mem_res_blk_i   (mem_res_blk_i)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".i_ready"},   128'(i_ready_o),     128'h0);
    chk({tag, ".d_ready"},   128'(d_ready_o),     128'h0);
    chk({tag, ".i_res_v"},   128'(i_res_valid_o), 128'h0);
    chk({tag, ".i_res_blk"}, i_res_blk_o,         128'h0);
    chk({tag, ".d_res_v"},   128'(d_res_valid_o), 128'h0);
    chk({tag, ".d_res_blk"}, d_res_blk_o,         128'h0);
    chk({tag, ".mem_v"},     128'(mem_valid_o),   128'h0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    i_valid_i = 1'b0; i_addr_i = '0; i_uncached_i = 1'b0;
    d_valid_i = 1'b0; d_addr_i = '0; d_rw_i = 1'b0; d_wdata_i = '0; d_uncached_i = 1'b0;
    mem_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_blk_i = '0;

    // Reset state
    to_neg(); to_neg(); settle();
    chk_quiet("rst");
    chk("rst.mem_addr",  128'(mem_addr_o),     128'h0);
    chk("rst.mem_rw",    128'(mem_rw_o),       128'h0);
    chk("rst.mem_wdata", mem_wdata_o,          128'h0);
    chk("rst.mem_unc",   128'(mem_uncached_o), 128'h0);

    // 1. I only, response at N+3
    to_neg(); rst_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h10; i_uncached_i = 1'b1; settle();
    chk("t1.i_ready_N", 128'(i_ready_o), 128'h1);
    chk("t1.d_ready_N", 128'(d_ready_o), 128'h0);
    chk("t1.mem_v_N",   128'(mem_valid_o), 128'h0);
    to_neg(); i_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    chk("t1.mem_v_N1",  128'(mem_valid_o), 128'h1);
    chk("t1.mem_addr",  128'(mem_addr_o), 128'h10);
    chk("t1.mem_rw",    128'(mem_rw_o), 128'h0);
    chk("t1.mem_wdata", mem_wdata_o, 128'h0);
    chk("t1.mem_unc",   128'(mem_uncached_o), 128'h1);
    chk("t1.i_ready_N1", 128'(i_ready_o), 128'h0);
    to_neg(); mem_ready_i = 1'b0; settle();
    chk("t1.mem_v_N2",  128'(mem_valid_o), 128'h0);
    chk("t1.i_res_N2",  128'(i_res_valid_o), 128'h0);
    to_neg(); mem_res_valid_i = 1'b1; mem_res_blk_i = BLK1; settle();
    chk("t1.i_res_v",   128'(i_res_valid_o), 128'h1);
    chk("t1.i_res_blk", i_res_blk_o, BLK1);
    chk("t1.d_res_v",   128'(d_res_valid_o), 128'h0);
    chk("t1.d_res_blk", d_res_blk_o, 128'h0);
    to_neg(); mem_res_valid_i = 1'b0; mem_res_blk_i = '0; settle();
    chk_quiet("t1.after");

    // 2. Fresh reset, I and D valid together: I first, then D
    to_neg(); rst_i = 1'b1; settle();
    to_neg(); rst_i = 1'b0;
    i_valid_i = 1'b1; i_addr_i = 32'h20; i_uncached_i = 1'b0;
    d_valid_i = 1'b1; d_addr_i = 32'hF8; d_rw_i = 1'b1; d_wdata_i = WDATA; d_uncached_i = 1'b0;
    settle();
    chk("t2.i_first", 128'(i_ready_o), 128'h1);
    chk("t2.d_wait",  128'(d_ready_o), 128'h0);
    to_neg(); i_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    chk("t2.i_mem_addr", 128'(mem_addr_o), 128'h20);
    chk("t2.i_mem_rw",   128'(mem_rw_o), 128'h0);
    chk("t2.d_busy",     128'(d_ready_o), 128'h0);
    to_neg(); mem_ready_i = 1'b0; settle();
    to_neg(); mem_res_valid_i = 1'b1; mem_res_blk_i = BLK2; settle();
    chk("t2.i_res_blk", i_res_blk_o, BLK2);
    chk("t2.d_no_res",  128'(d_res_valid_o), 128'h0);
    to_neg(); mem_res_valid_i = 1'b0; settle();
    chk("t2.d_second", 128'(d_ready_o), 128'h1);

    // 3. Backpressure on the D write-back for 5 cycles
    for (int i = 0; i < 5; i++) begin
      to_neg(); d_valid_i = 1'b0; mem_ready_i = 1'b0; settle();
      chk("t3.mem_v",     128'(mem_valid_o), 128'h1);
      chk("t3.mem_addr",  128'(mem_addr_o), 128'hF8);
      chk("t3.mem_rw",    128'(mem_rw_o), 128'h1);
      chk("t3.mem_wdata", mem_wdata_o, WDATA);
    end
    to_neg(); mem_ready_i = 1'b1; settle();
    chk("t3.mem_v_ready", 128'(mem_valid_o), 128'h1);
    to_neg(); mem_ready_i = 1'b0; settle();
    chk("t3.wait_mem_v", 128'(mem_valid_o), 128'h0);
    to_neg(); mem_res_valid_i = 1'b1; mem_res_blk_i = BLK3; settle();
    chk("t3.d_res_v",   128'(d_res_valid_o), 128'h1);
    chk("t3.d_res_blk", d_res_blk_o, BLK3);
    chk("t3.i_res_v",   128'(i_res_valid_o), 128'h0);

    // 4. Both valid again (I wins after D), flush during the I WAIT
    to_neg(); mem_res_valid_i = 1'b0;
    i_valid_i = 1'b1; i_addr_i = 32'h40; d_valid_i = 1'b1; d_addr_i = 32'h80; d_rw_i = 1'b0;
    settle();
    chk("t4.i_alt", 128'(i_ready_o), 128'h1);
    chk("t4.d_alt", 128'(d_ready_o), 128'h0);
    to_neg(); i_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    to_neg(); mem_ready_i = 1'b0; flush_i = 1'b1; settle();
    chk("t4.d_held", 128'(d_ready_o), 128'h0);
    to_neg(); flush_i = 1'b0; mem_res_valid_i = 1'b1; mem_res_blk_i = BLK4; settle();
    chk("t4.swallow_v",   128'(i_res_valid_o), 128'h0);
    chk("t4.swallow_blk", i_res_blk_o, 128'h0);
    chk("t4.d_res_v",     128'(d_res_valid_o), 128'h0);
    to_neg(); mem_res_valid_i = 1'b0; settle();
    chk("t4.d_next", 128'(d_ready_o), 128'h1);
    to_neg(); d_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    chk("t4.d_mem_addr", 128'(mem_addr_o), 128'h80);
    chk("t4.d_mem_rw",   128'(mem_rw_o), 128'h0);
    to_neg(); mem_ready_i = 1'b0; settle();
    to_neg(); mem_res_valid_i = 1'b1; mem_res_blk_i = BLK5; settle();
    chk("t4.d_res_blk", d_res_blk_o, BLK5);

    // 5. Flush in IDLE with only I valid
    to_neg(); mem_res_valid_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h50; flush_i = 1'b1; settle();
    chk("t5.no_grant", 128'(i_ready_o), 128'h0);
    chk("t5.no_d",     128'(d_ready_o), 128'h0);
    to_neg(); flush_i = 1'b0; settle();
    chk("t5.grant", 128'(i_ready_o), 128'h1);
    to_neg(); i_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    chk("t5.mem_addr", 128'(mem_addr_o), 128'h50);
    to_neg(); mem_ready_i = 1'b0; settle();
    to_neg(); mem_res_valid_i = 1'b1; mem_res_blk_i = BLK1; settle();
    chk("t5.i_res_v", 128'(i_res_valid_o), 128'h1);

    // 6. Reset during a D WAIT, then a stray response
    to_neg(); mem_res_valid_i = 1'b0; d_valid_i = 1'b1; d_addr_i = 32'h60; settle();
    chk("t6.d_grant", 128'(d_ready_o), 128'h1);
    to_neg(); d_valid_i = 1'b0; mem_ready_i = 1'b1; settle();
    to_neg(); mem_ready_i = 1'b0; settle();
    to_neg(); rst_i = 1'b1; i_valid_i = 1'b1; i_addr_i = 32'h70;
    mem_res_valid_i = 1'b1; mem_res_blk_i = BLK2; settle();
    chk_quiet("t6.in_rst");
    to_neg(); rst_i = 1'b0; d_valid_i = 1'b1; settle();
    chk("t6.stray_d",   128'(d_res_valid_o), 128'h0);
    chk("t6.stray_i",   128'(i_res_valid_o), 128'h0);
    chk("t6.mem_v",     128'(mem_valid_o), 128'h0);
    chk("t6.mem_addr",  128'(mem_addr_o), 128'h0);
    chk("t6.i_wins",    128'(i_ready_o), 128'h1);
    chk("t6.d_loses",   128'(d_ready_o), 128'h0);

    to_neg();
    i_valid_i = 1'b0; d_valid_i = 1'b0; mem_res_valid_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
